// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with an optional 2-entry skid buffer,
// flush-to-bubble and a fixed bubble value on out_data while empty.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             w_acc;
    logic             w_emi;
    logic             w_load_in;
    logic             w_load_skid;
    logic             w_to_skid;

    assign w_acc       = in_valid && in_ready;
    assign w_emi       = out_valid && out_ready;
    assign w_load_in   = w_acc && (r_state == S_EMPTY || (r_state == S_ONE && w_emi));
    assign w_load_skid = r_state == S_FULL && w_emi;
    assign w_to_skid   = w_acc && r_state == S_ONE && !w_emi;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= w_next != S_FULL;
        end
    end

    // Payload registers need no reset: out_data is masked to RESET_VAL while empty.
    always_ff @(posedge clk) begin
        if (w_load_in)
            r_main <= in_data;
        else if (w_load_skid)
            r_main <= r_skid;
        if (w_to_skid)
            r_skid <= in_data;
    end

    always_comb begin
        w_next = r_state;
        if (flush)
            w_next = S_EMPTY;
        else
            unique case (r_state)
                S_EMPTY: w_next = w_acc ? S_ONE : S_EMPTY;
                S_ONE:   w_next = (w_acc && !w_emi) ? S_FULL : (w_emi && !w_acc) ? S_EMPTY : S_ONE;
                S_FULL:  w_next = w_emi ? S_ONE : S_FULL;
                default: w_next = S_EMPTY;
            endcase
    end

    always_comb begin
        out_valid = r_state != S_EMPTY;
        in_ready  = SKID ? r_in_ready : (out_ready || !out_valid);
        out_data  = out_valid ? r_main : RESET_VAL;
        occupancy = r_state;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the pipeline CPU. It replaces the fixed 32-bit enable-style inter-stage latches (IF/ID and onward) with a valid/ready handshake stage. The stage has a configurable payload width, an optional 2-entry skid buffer that breaks the ready path, a flush input that inserts a bubble, and a deterministic bubble value on the data output. One instance sits between each pair of pipeline stages; the payload is the concatenated stage fields, e.g. {instr, pc}.

Parameters:
WIDTH, 64, payload width in bits (>=1)
RESET_VAL, {WIDTH{1'b0}}, value driven on out_data whenever out_valid=0 (the NOP/bubble encoding)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready

Ports:
clk  input  1  rising-edge clock, the only clock
rst  input  1  synchronous reset, active-low (sampled at posedge clk; 0 = reset)
flush  input  1  discard all held and incoming payloads this cycle
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  downstream payload valid
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  payload to downstream; RESET_VAL when out_valid=0
occupancy  output  2  number of held entries (0..2; max 1 when SKID=0)

Behaviour:
- acc = in_valid & in_ready; emi = out_valid & out_ready; all state updates at posedge clk.
- Priority per edge: rst==0 > flush > handshake.
- Reset (rst==0): both entries empty, out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1 from the first cycle after reset. Reset mid-transfer drops all entries; no payload survives.
- Flush=1: same as reset for data state. Main and skid are emptied, and any payload accepted in the same cycle is dropped. in_ready is unaffected in the flush cycle and is 1 in the next cycle.
- Latency: a payload accepted at edge N appears on out_data with out_valid=1 after edge N (1 cycle), provided the stage was empty or emitting.
- Ordering is strictly FIFO; no payload is duplicated or lost except by flush/reset.
- Hold: while out_valid=1 & out_ready=0, out_data and out_valid are stable.
- SKID=1, states by occupancy:
  - EMPTY(0): in_ready=1. acc -> ONE, main<=in_data.
  - ONE(1): in_ready=1.
    - acc&emi -> ONE, main<=in_data.
    - acc&!emi -> FULL, skid<=in_data.
    - emi&!acc -> EMPTY.
    - neither -> hold.
  - FULL(2): in_ready=0, so acc is impossible. emi -> ONE, main<=skid. Otherwise hold.
  - in_ready is a register output, =!(next occupancy==2), with no combinational path from out_ready.
- SKID=0: in_ready = out_ready | !out_valid (combinational); occupancy only 0/1. EMPTY/ONE transitions are as above; acc&!emi cannot occur in ONE.
- When entering EMPTY (emit or flush), out_data switches to RESET_VAL in the same cycle out_valid drops.
- out_valid is registered (=occupancy!=0); out_data is driven from the main entry, or RESET_VAL when empty.
- in_data is ignored when in_valid=0. X on in_data while in_valid=0 must not propagate to out_data.

Test Plan:
- Reset: hold rst=0 2 cycles with in_valid=1, in_data=0xDEAD -> out_valid=0, out_data=RESET_VAL, occupancy=0; rst=1 -> in_ready=1 next cycle, nothing emitted.
- Streaming: out_ready=1, send 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33 on consecutive cycles, 1-cycle latency, occupancy stays 1.
- Backpressure (SKID=1): out_ready=0, send 0xA1,0xA2 -> occupancy 2, in_ready=0, out_data=0xA1 held. out_ready=1 -> 0xA1 then 0xA2, in_ready=1 one cycle after first emit.
- Flush: occupancy=2 (0xB1,0xB2), assert flush with in_valid=1, in_data=0xB3 -> next cycle out_valid=0, out_data=RESET_VAL, occupancy=0; 0xB3 never emitted.
- SKID=0 comb ready: out_valid=1, toggle out_ready 1/0 -> in_ready tracks out_ready same cycle; random valid/ready for 10k cycles -> scoreboard shows in-order, lossless, no duplicates.
- Reset mid-stall: occupancy=2 then rst=0 one cycle -> occupancy=0, out_valid=0; subsequent 0xC1 passes normally.
